// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types for the reservation station / issue scheduler.
//   op_e        : renamed opcode set handled by the station
//   fu_e        : functional-unit class / slot
//   rs_entry_t  : one station entry
//   op_to_fu()  : ALU vs MEM class of an opcode
//   uses_rs2()  : whether the opcode reads its second source
package rs_issue_scheduler_pkg;

  localparam int unsigned PREG_W = 6;
  localparam int unsigned ROB_W  = 6;
  localparam int unsigned NUM_FU = 3;

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAddi, OpXor, OpAndi, OpSra, OpLw, OpSw
  } op_e;

  typedef enum logic [1:0] {
    FuAlu0, FuAlu1, FuMem
  } fu_e;

  typedef struct packed {
    logic              valid;
    op_e               op;
    logic [PREG_W-1:0] ps1;
    logic              rdy1;
    logic [PREG_W-1:0] ps2;
    logic              rdy2;
    logic [PREG_W-1:0] pd;
    logic [31:0]       imm;
    logic [ROB_W-1:0]  rob_idx;
  } rs_entry_t;

  // ALU-class ops report FuAlu0; the ALU0/ALU1 split is decided at select time.
  function automatic fu_e op_to_fu(op_e op);
    return (op == OpLw || op == OpSw) ? FuMem : FuAlu0;
  endfunction

  function automatic logic uses_rs2(op_e op);
    return !(op == OpAddi || op == OpAndi || op == OpLw);
  endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Oldest / second-oldest picker over a request mask.
//   req_i       : candidate entries
//   age_i       : per-entry age (smaller = older), unique among candidates
//   first_oh_o  : one-hot oldest candidate (zero if none)
//   second_oh_o : one-hot second-oldest candidate (zero if fewer than two)
module rs_issue_scheduler_age_select #(
  parameter int unsigned N    = 16,
  parameter int unsigned AgeW = 6
) (
  input  logic [N-1:0]           req_i,
  input  logic [N-1:0][AgeW-1:0] age_i,
  output logic [N-1:0]           first_oh_o,
  output logic [N-1:0]           second_oh_o
);

  logic [N-1:0] rem;

  always_comb begin
    first_oh_o = '0;
    for (int i = 0; i < N; i++) begin
      first_oh_o[i] = req_i[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && req_i[j] && (age_i[j] < age_i[i])) first_oh_o[i] = 1'b0;
      end
    end
  end

  // Second-oldest is simply the oldest once the winner is removed.
  always_comb begin
    rem         = req_i & ~first_oh_o;
    second_oh_o = '0;
    for (int i = 0; i < N; i++) begin
      second_oh_o[i] = rem[i];
      for (int j = 0; j < N; j++) begin
        if (j != i && rem[j] && (age_i[j] < age_i[i])) second_oh_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation station + issue scheduler feeding ALU0, ALU1 and MEM.
//   clk, rst, flush     : clock, sync active-high reset, squash-all
//   disp_*              : dispatch request / entry fields, disp_ready back-pressure
//   rob_head            : oldest in-flight ROB index (age reference)
//   wb_valid, wb_tag    : writeback wakeup broadcasts
//   fu_ready            : [0]=ALU0 [1]=ALU1 [2]=MEM can accept
//   iss_valid, iss_*    : registered per-FU issue strobe and packed entry fields
//   rs_count            : occupied entries
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned NUM_WB   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [2:0]                 disp_op,
  input  logic [PREG_W-1:0]          disp_ps1,
  input  logic [PREG_W-1:0]          disp_ps2,
  input  logic                       disp_rdy1,
  input  logic                       disp_rdy2,
  input  logic [PREG_W-1:0]          disp_pd,
  input  logic [31:0]                disp_imm,
  input  logic [ROB_W-1:0]           disp_rob_idx,
  input  logic [ROB_W-1:0]           rob_head,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*PREG_W-1:0]   wb_tag,
  input  logic [NUM_FU-1:0]          fu_ready,
  output logic [NUM_FU-1:0]          iss_valid,
  output logic [NUM_FU*3-1:0]        iss_op,
  output logic [NUM_FU*PREG_W-1:0]   iss_ps1,
  output logic [NUM_FU*PREG_W-1:0]   iss_ps2,
  output logic [NUM_FU*PREG_W-1:0]   iss_pd,
  output logic [NUM_FU*32-1:0]       iss_imm,
  output logic [NUM_FU*ROB_W-1:0]    iss_rob_idx,
  output logic [$clog2(RS_DEPTH):0]  rs_count
);

  localparam int unsigned IdxW = $clog2(RS_DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  rs_entry_t        entries_q [RS_DEPTH];
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic tag_hit(logic [PREG_W-1:0] tag, logic [NUM_WB-1:0] v,
                                   logic [NUM_WB*PREG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (v[k] && tags[k*PREG_W +: PREG_W] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-entry status, all from registered state.
  logic [RS_DEPTH-1:0]            valid, eligible, is_mem;
  logic [RS_DEPTH-1:0][ROB_W-1:0] age;

  always_comb begin
    valid    = '0;
    eligible = '0;
    is_mem   = '0;
    age      = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      valid[i]    = entries_q[i].valid;
      eligible[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
      is_mem[i]   = (op_to_fu(entries_q[i].op) == FuMem);
      age[i]      = entries_q[i].rob_idx - rob_head;
    end
  end

  logic [RS_DEPTH-1:0] alu_first, alu_second, mem_first, unused_mem_second;

  rs_issue_scheduler_age_select #(
    .N    (RS_DEPTH),
    .AgeW (ROB_W)
  ) u_alu_select (
    .req_i       (eligible & ~is_mem),
    .age_i       (age),
    .first_oh_o  (alu_first),
    .second_oh_o (alu_second)
  );

  // MEM candidates include non-eligible entries so a blocked older op holds younger ones.
  rs_issue_scheduler_age_select #(
    .N    (RS_DEPTH),
    .AgeW (ROB_W)
  ) u_mem_select (
    .req_i       (valid & is_mem),
    .age_i       (age),
    .first_oh_o  (mem_first),
    .second_oh_o (unused_mem_second)
  );

  logic [NUM_FU-1:0][RS_DEPTH-1:0] sel;
  logic [RS_DEPTH-1:0]             issue_mask;
  logic [CntW-1:0]                 n_issued;

  always_comb begin
    sel = '0;
    if (fu_ready[0]) begin
      sel[0] = alu_first;
      if (fu_ready[1]) sel[1] = alu_second;
    end else if (fu_ready[1]) begin
      sel[1] = alu_first;
    end
    if (fu_ready[2] && |(mem_first & eligible)) sel[2] = mem_first;
    issue_mask = sel[0] | sel[1] | sel[2];
  end

  always_comb begin
    n_issued = '0;
    for (int i = 0; i < RS_DEPTH; i++) n_issued = n_issued + CntW'(issue_mask[i]);
  end

  // One-hot selects, so a priority mux is equivalent to an OR mux.
  rs_entry_t pick [NUM_FU];

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      pick[f] = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (sel[f][i]) pick[f] = entries_q[i];
      end
    end
  end

  logic unused_pick;
  always_comb begin
    unused_pick = ^unused_mem_second;
    for (int f = 0; f < NUM_FU; f++) begin
      unused_pick = unused_pick ^ pick[f].valid ^ pick[f].rdy1 ^ pick[f].rdy2;
    end
  end

  // Dispatch: lowest free slot; freeing this cycle does not make a slot usable yet.
  logic [IdxW-1:0] free_idx;
  logic            accept;
  rs_entry_t       new_entry;
  op_e             d_op;

  assign disp_ready = (count_q < CntW'(RS_DEPTH));
  assign accept     = disp_valid && disp_ready && !flush;
  assign rs_count   = count_q;

  always_comb begin
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) free_idx = IdxW'(i);
    end
  end

  always_comb begin
    d_op              = op_e'(disp_op);
    new_entry.valid   = 1'b1;
    new_entry.op      = d_op;
    new_entry.ps1     = disp_ps1;
    new_entry.rdy1    = disp_rdy1 || (disp_ps1 == '0) || tag_hit(disp_ps1, wb_valid, wb_tag);
    new_entry.ps2     = disp_ps2;
    new_entry.rdy2    = !uses_rs2(d_op) || disp_rdy2 || (disp_ps2 == '0) ||
                        tag_hit(disp_ps2, wb_valid, wb_tag);
    new_entry.pd      = disp_pd;
    new_entry.imm     = disp_imm;
    new_entry.rob_idx = disp_rob_idx;
    count_d           = count_q + CntW'(accept) - n_issued;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < RS_DEPTH; i++) entries_q[i].valid <= 1'b0;
      count_q   <= '0;
      iss_valid <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (issue_mask[i]) begin
          entries_q[i].valid <= 1'b0;
        end else if (entries_q[i].valid) begin
          if (tag_hit(entries_q[i].ps1, wb_valid, wb_tag)) entries_q[i].rdy1 <= 1'b1;
          if (tag_hit(entries_q[i].ps2, wb_valid, wb_tag)) entries_q[i].rdy2 <= 1'b1;
        end
      end
      if (accept) entries_q[free_idx] <= new_entry;
      count_q <= count_d;
      for (int f = 0; f < NUM_FU; f++) iss_valid[f] <= |sel[f];
    end
  end

  // Payload needs no reset; it is qualified by iss_valid.
  always_ff @(posedge clk) begin
    for (int f = 0; f < NUM_FU; f++) begin
      iss_op[f*3 +: 3]              <= pick[f].op;
      iss_ps1[f*PREG_W +: PREG_W]   <= pick[f].ps1;
      iss_ps2[f*PREG_W +: PREG_W]   <= pick[f].ps2;
      iss_pd[f*PREG_W +: PREG_W]    <= pick[f].pd;
      iss_imm[f*32 +: 32]           <= pick[f].imm;
      iss_rob_idx[f*ROB_W +: ROB_W] <= pick[f].rob_idx;
    end
  end

endmodule
